imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
Instruction fetch sequencer for the asynchronous-read instruction memory. It owns the program counter and drives the memory address. It captures the returned word into the instruction register (IR) and presents it to decode with a valid/ready handshake. It also handles start, stall, branch/jump redirect, halt detection and PC wrap-around.

Parameters:
ADDR_WIDTH, 6, word address width; matches instruction memory depth 2**ADDR_WIDTH
DATA_WIDTH, 32, instruction width
RESET_PC, 0, PC value after reset
HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins fetching from current PC
imem_addr  out  ADDR_WIDTH  address to instruction memory (combinational = pc)
imem_data  in  DATA_WIDTH  instruction word from memory (async read, same cycle)
ir  out  DATA_WIDTH  instruction register
ir_pc  out  ADDR_WIDTH  address the IR word was fetched from
ir_valid  out  1  IR holds an unconsumed instruction
ir_ready  in  1  decode accepts IR this cycle (handshake when ir_valid & ir_ready)
redirect  in  1  branch/jump taken; flush and refetch
redirect_addr  in  ADDR_WIDTH  redirect target
busy  out  1  state == FETCH
halted  out  1  state == HALT
wrap_err  out  1  sticky; PC incremented past 2**ADDR_WIDTH-1

Behaviour:
- Reset (async, immediate) values:
  - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, wrap_err=0.
  - state=IDLE, so busy=0 and halted=0.
- imem_addr = pc at all times; no registered read.
- States: IDLE, FETCH, HALT.
- IDLE:
  - start -> FETCH next edge; no load that cycle.
  - redirect in IDLE: pc<=redirect_addr and stay IDLE. Takes priority over start in the same cycle.
- FETCH, load condition = !ir_valid | ir_ready:
  - On load: ir<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
  - If imem_data==HALT_INSTR on load: the word is loaded and presented normally, pc is not incremented, state->HALT.
  - Stall (ir_valid & !ir_ready): ir, ir_pc, pc and ir_valid all hold.
- Redirect (any state except IDLE), highest priority:
  - pc<=redirect_addr and ir_valid<=0 (flush); no load that cycle.
  - State->FETCH, so HALT is exited.
  - A simultaneous ir_valid&ir_ready counts as consumed; the flush discards nothing extra.
- HALT:
  - No loads; pc frozen.
  - IR drains normally: ir_valid clears once ir_ready is seen.
  - start is ignored; only redirect or reset leaves HALT.
- Latency: start sampled at edge E0 -> FETCH after E0 -> IR loaded at E1, ir_valid=1 after E1. Sustained throughput is 1 instruction/cycle with ir_ready held high.
- Redirect sampled at edge E0 -> ir_valid=0 after E0 -> target word valid after E1 (one bubble).
- Wrap-around: pc increments modulo 2**ADDR_WIDTH; wrap_err is set on the increment from all-ones to 0. Only reset clears it.
- Reset mid-operation: all state returns to reset values asynchronously; the in-flight IR is discarded.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds two 16-bit saturating counters, cleared by reset.
  - fetch_count (out, 16): increments on each IR load.
  - stall_count (out, 16): increments each FETCH cycle with ir_valid & !ir_ready.
  - Both hold at 16'hFFFF.
- Not defined: both ports still exist, tied to 0, with no counter logic.

Test Plan:
- Memory words 0..3 = 0x11,0x22,0x33,0x44; reset, start, ir_ready=1 -> ir=0x11,0x22,0x33,0x44 on consecutive cycles starting one cycle after FETCH entry; ir_pc=0,1,2,3.
- Same program, ir_ready=0 for 3 cycles while ir=0x22 -> ir/ir_pc/imem_addr hold (ir_pc=1, imem_addr=2); after release, 0x33 follows next cycle; stall_count=3 with FETCH_PERF_EN.
- During fetch at pc=2, redirect=1, redirect_addr=40 -> ir_valid=0 next cycle, then ir=mem[40], ir_pc=40.
- Word 5 = HALT_INSTR -> IR presents HALT_INSTR with ir_pc=5; halted=1; pc stays 5; start has no effect; redirect to 0 -> busy=1 and fetching resumes from 0.
- redirect_addr=62 with 64-word memory, run 3 fetches -> ir_pc=62,63,0 and wrap_err=1; assert reset mid-stream -> wrap_err=0, ir_valid=0, imem_addr=RESET_PC immediately.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, loads the IR from async-read imem, valid/ready to decode.
// Optional FETCH_PERF_EN macro adds saturating fetch/stall counters (ports tied to 0 otherwise).
module imem_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic [ADDR_WIDTH-1:0] ir_pc_o,
    output logic                  ir_valid_o,
    input  logic                  ir_ready_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic                  wrap_err_o,
    output logic [15:0]           fetch_count_o,
    output logic [15:0]           stall_count_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [ADDR_WIDTH-1:0] ir_pc_q, ir_pc_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  wrap_err_q, wrap_err_d;
    logic                  load;
    logic                  stall;

    assign load  = (state_q == ST_FETCH) && !redirect_i && (!ir_valid_q || ir_ready_i);
    assign stall = (state_q == ST_FETCH) && ir_valid_q && !ir_ready_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        wrap_err_d = wrap_err_q;

        if (ir_valid_q && ir_ready_i) begin
            ir_valid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            if (redirect_i) begin
                pc_d = redirect_addr_i;
            end else if (start_i) begin
                state_d = ST_FETCH;
            end
        end else if (redirect_i) begin
            // Flush: whatever decode accepted this cycle is already counted as consumed.
            pc_d       = redirect_addr_i;
            ir_valid_d = 1'b0;
            state_d    = ST_FETCH;
        end else if (load) begin
            ir_d       = imem_data_i;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (imem_data_i == HALT_INSTR) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_q + 1'b1;
                if (pc_q == {ADDR_WIDTH{1'b1}}) begin
                    wrap_err_d = 1'b1;
                end
            end
        end else if (stall) begin
            ir_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            wrap_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            wrap_err_q <= wrap_err_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign ir_o        = ir_q;
    assign ir_pc_o     = ir_pc_q;
    assign ir_valid_o  = ir_valid_q;
    assign busy_o      = (state_q == ST_FETCH);
    assign halted_o    = (state_q == ST_HALT);
    assign wrap_err_o  = wrap_err_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (load && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign stall_count_o = stall_cnt_q;
`else
    assign fetch_count_o = 16'd0;
    assign stall_count_o = 16'd0;
`endif

endmodule
